// File: rtl/vpg_timing.sv
// vpg_timing: mode-switchable raster timing generator; requested modes take effect only at frame boundaries.
module vpg_timing #(
  parameter int DEFAULT_MODE = 4,
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          vpg_mode_change,
  input  logic [3:0]    vpg_mode,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic [3:0]    active_mode,
  output logic          mode_pending
);
  localparam logic [3:0] DEF = (DEFAULT_MODE > 4) ? 4'd0 : 4'(DEFAULT_MODE);
  localparam logic DEF_NEG = (DEF == 4'd0) || (DEF == 4'd2);
  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_q, x_d, y_q, y_d;
  logic [CW-1:0] hact, hfp, hsy, htot, vact, vfp, vsy, vtot;
  logic [3:0] active_mode_q, active_mode_d, pending_mode_q, pending_mode_d;
  logic mode_pending_q, mode_pending_d, hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic neg, h_last, v_last, sw, cap, de_n;
  always_comb begin
    {hact, hfp, hsy, htot, vact, vfp, vsy, vtot, neg} =
      {CW'(640), CW'(16), CW'(96), CW'(800), CW'(480), CW'(10), CW'(2), CW'(525), 1'b1};
    case (active_mode_q)
      4'd1: {hact, hfp, hsy, htot, vact, vfp, vsy, vtot, neg} =
        {CW'(800), CW'(40), CW'(128), CW'(1056), CW'(600), CW'(1), CW'(4), CW'(628), 1'b0};
      4'd2: {hact, hfp, hsy, htot, vact, vfp, vsy, vtot, neg} =
        {CW'(1024), CW'(24), CW'(136), CW'(1344), CW'(768), CW'(3), CW'(6), CW'(806), 1'b1};
      4'd3: {hact, hfp, hsy, htot, vact, vfp, vsy, vtot, neg} =
        {CW'(1280), CW'(110), CW'(40), CW'(1650), CW'(720), CW'(5), CW'(5), CW'(750), 1'b0};
      4'd4: {hact, hfp, hsy, htot, vact, vfp, vsy, vtot, neg} =
        {CW'(1920), CW'(88), CW'(44), CW'(2200), CW'(1080), CW'(4), CW'(5), CW'(1125), 1'b0};
      default: ;
    endcase
  end
  // Every register is written every clock so held values are explicit next-states.
  always_comb begin
    h_last = h_cnt_q == htot - CW'(1);
    v_last = v_cnt_q == vtot - CW'(1);
    sw = clk_en && h_last && v_last && mode_pending_q;
    cap = clk_en && vpg_mode_change;
    de_n = (h_cnt_q < hact) && (v_cnt_q < vact);
    h_cnt_d = !clk_en ? h_cnt_q : h_last ? '0 : h_cnt_q + CW'(1);
    v_cnt_d = !(clk_en && h_last) ? v_cnt_q : v_last ? '0 : v_cnt_q + CW'(1);
    active_mode_d = sw ? pending_mode_q : active_mode_q;
    pending_mode_d = !cap ? pending_mode_q : (vpg_mode > 4'd4) ? 4'd0 : vpg_mode;
    mode_pending_d = cap || (mode_pending_q && !sw);
    hs_d = !clk_en ? hs_q : neg ^ (h_cnt_q >= hact + hfp && h_cnt_q < hact + hfp + hsy);
    vs_d = !clk_en ? vs_q : neg ^ (v_cnt_q >= vact + vfp && v_cnt_q < vact + vfp + vsy);
    de_d = clk_en ? de_n : de_q;
    x_d = !clk_en ? x_q : de_n ? h_cnt_q : '0;
    y_d = !clk_en ? y_q : de_n ? v_cnt_q : '0;
    fs_d = clk_en ? (h_cnt_q == '0 && v_cnt_q == '0) : fs_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      active_mode_q <= DEF;
      pending_mode_q <= '0;
      mode_pending_q <= 1'b0;
      hs_q <= DEF_NEG;
      vs_q <= DEF_NEG;
      de_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      fs_q <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      active_mode_q <= active_mode_d;
      pending_mode_q <= pending_mode_d;
      mode_pending_q <= mode_pending_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      x_q <= x_d;
      y_q <= y_d;
      fs_q <= fs_d;
    end
  end
  assign hs = hs_q;
  assign vs = vs_q;
  assign de = de_q;
  assign x = x_q;
  assign y = y_q;
  assign frame_start = fs_q;
  assign active_mode = active_mode_q;
  assign mode_pending = mode_pending_q;
endmodule

// File: tb/tb_vpg_timing.sv
// tb_vpg_timing: directed stimulus against a pixel-index timing model; long frames are skipped by depositing counter values.
module tb_vpg_timing;
  logic clk = 1'b0;
  logic reset, clk_en, vpg_mode_change, hs, vs, de, frame_start, mode_pending;
  logic [3:0] vpg_mode, active_mode;
  logic [11:0] x, y, jh, jv;
  vpg_timing dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .vpg_mode_change(vpg_mode_change),
    .vpg_mode(vpg_mode), .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .active_mode(active_mode), .mode_pending(mode_pending)
  );
  always #5 clk = ~clk;
  int HA[5] = '{640, 800, 1024, 1280, 1920};
  int HF[5] = '{16, 40, 24, 110, 88};
  int HS[5] = '{96, 128, 136, 40, 44};
  int HT[5] = '{800, 1056, 1344, 1650, 2200};
  int VA[5] = '{480, 600, 768, 720, 1080};
  int VF[5] = '{10, 1, 3, 5, 4};
  int VS[5] = '{2, 4, 6, 5, 5};
  int VT[5] = '{525, 628, 806, 750, 1125};
  int NG[5] = '{1, 0, 1, 0, 0};
  int p, mode, pend, pmode, e_x, e_y;
  logic e_hs, e_vs, e_de, e_fs;
  int checks = 0, passes = 0;
  int c_de, c_hs, c_vs, first_fs, first_hs, nr;
  int r[2];
  // Model tracks the linear pixel index within the frame; h/v fall out of div/mod.
  task automatic model(input logic rr, ee, cc, input logic [3:0] m);
    int h, v, tot;
    if (rr) begin
      p = 0; mode = 4; pend = 0; pmode = 0;
      e_hs = NG[4] != 0; e_vs = NG[4] != 0; e_de = 0; e_fs = 0; e_x = 0; e_y = 0;
    end else if (ee) begin
      h = p % HT[mode];
      v = p / HT[mode];
      tot = HT[mode] * VT[mode];
      e_de = h < HA[mode] && v < VA[mode];
      e_hs = (NG[mode] != 0) ^ (h >= HA[mode] + HF[mode] && h < HA[mode] + HF[mode] + HS[mode]);
      e_vs = (NG[mode] != 0) ^ (v >= VA[mode] + VF[mode] && v < VA[mode] + VF[mode] + VS[mode]);
      e_x = e_de ? h : 0;
      e_y = e_de ? v : 0;
      e_fs = p == 0;
      if (p == tot - 1 && pend != 0) begin mode = pmode; pend = 0; end
      p = (p == tot - 1) ? 0 : p + 1;
      if (cc) begin pmode = (m > 4'd4) ? 0 : int'(m); pend = 1; end
    end
  endtask
  task automatic compare();
    logic [32:0] a, ex;
    a = {hs, vs, de, frame_start, x, y, active_mode, mode_pending};
    ex = {e_hs, e_vs, e_de, e_fs, 12'(e_x), 12'(e_y), 4'(mode), pend != 0};
    checks++;
    if (a === ex) passes++;
    else $display("FAIL model t=%0t got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d mode=%0d pend=%b expected hs=%b vs=%b de=%b fs=%b x=%0d y=%0d mode=%0d pend=%0d",
                  $time, hs, vs, de, frame_start, x, y, active_mode, mode_pending,
                  e_hs, e_vs, e_de, e_fs, e_x, e_y, mode, pend);
  endtask
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s got %0d expected %0d", n, act, exp);
  endtask
  task automatic cyc(input logic rr, ee, cc, input logic [3:0] m);
    reset = rr; clk_en = ee; vpg_mode_change = cc; vpg_mode = m;
    @(posedge clk);
    model(rr, ee, cc, m);
    @(negedge clk);
    compare();
  endtask
  task automatic run(input int n);
    logic pde;
    c_de = 0; c_hs = 0; c_vs = 0; first_fs = -1; first_hs = -1; nr = 0; pde = de;
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, 0);
      c_de += int'(de); c_hs += int'(hs); c_vs += int'(vs);
      if (frame_start && first_fs < 0) first_fs = i;
      if (hs && first_hs < 0) first_hs = i;
      if (de && !pde) begin if (nr < 2) r[nr] = i; nr++; end
      pde = de;
    end
  endtask
  // Deposit counters during a disabled cycle to skip to a chosen raster position.
  task automatic jump(input int h, input int v);
    jh = 12'(h); jv = 12'(v);
    force dut.h_cnt_q = jh;
    force dut.v_cnt_q = jv;
    p = v * HT[mode] + h;
    cyc(0, 0, 0, 0);
    release dut.h_cnt_q;
    release dut.v_cnt_q;
  endtask
  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset_active_mode", int'(active_mode), 4);
    chk("reset_pending", int'(mode_pending), 0);
    chk("reset_de_fs_hs_vs", int'({de, frame_start, hs, vs}), 0);
    run(2200);
    chk("fhd_first_fs", first_fs, 0);
    chk("fhd_de_per_line", c_de, 1920);
    chk("fhd_hs_width", c_hs, 44);
    chk("fhd_hs_start", first_hs, 2008);
    cyc(0, 1, 1, 0);
    chk("strobe0_pending", int'(mode_pending), 1);
    chk("strobe0_still_fhd", int'(active_mode), 4);
    jump(2190, 1124);
    run(20);
    chk("switch_vga_fs", first_fs, 10);
    chk("switch_vga_mode", int'(active_mode), 0);
    chk("switch_vga_pending", int'(mode_pending), 0);
    run(790);
    chk("vga_hs_low", 790 - c_hs, 96);
    run(1700);
    chk("vga_line_len", r[1] - r[0], 800);
    jump(790, 524);
    run(20);
    chk("vga_frame_wrap", first_fs, 10);
    cyc(0, 1, 1, 1);
    run(5);
    cyc(0, 1, 1, 3);
    chk("two_strobe_mode", int'(active_mode), 0);
    jump(795, 524);
    run(10);
    chk("two_strobe_fs", first_fs, 5);
    chk("two_strobe_last_wins", int'(active_mode), 3);
    run(3300);
    chk("hd_line_len", r[1] - r[0], 1650);
    jump(1640, 723);
    run(10000);
    chk("hd_vs_lines", c_vs, 5 * 1650);
    jump(1640, 749);
    run(9);
    cyc(0, 1, 1, 2);
    chk("bnd_strobe_pending", int'(mode_pending), 1);
    chk("bnd_strobe_mode", int'(active_mode), 3);
    cyc(0, 1, 0, 0);
    chk("bnd_strobe_fs", int'(frame_start), 1);
    chk("bnd_strobe_keeps_mode", int'(active_mode), 3);
    run(100);
    chk("bnd_strobe_still_pending", int'(mode_pending), 1);
    jump(1640, 749);
    run(20);
    chk("bnd_next_fs", first_fs, 10);
    chk("bnd_next_mode", int'(active_mode), 2);
    for (int i = 0; i < 300; i++) cyc(0, i % 3 == 0, i % 3 == 1, 4'd1);
    chk("en_third_pending", int'(mode_pending), 0);
    chk("en_third_x", int'(x), 109);
    cyc(0, 1, 1, 1);
    chk("pre_reset_pending", int'(mode_pending), 1);
    run(50);
    cyc(1, 1, 0, 0);
    chk("midreset_mode", int'(active_mode), 4);
    chk("midreset_pending", int'(mode_pending), 0);
    chk("midreset_outs", int'({de, frame_start, hs, vs, x}), 0);
    cyc(0, 1, 1, 7);
    chk("post_reset_fs", int'(frame_start), 1);
    jump(2190, 1124);
    run(20);
    chk("code7_fs", first_fs, 10);
    chk("code7_mode", int'(active_mode), 0);
    run(1700);
    chk("code7_line_len", r[1] - r[0], 800);
    jump(790, 524);
    run(20);
    chk("code7_frame_wrap", first_fs, 10);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
